// File: rtl/xor_frame_checksum.sv
// Frame XOR/XNOR checksum over a valid/ready word stream, closed by in_last or MAX_LEN.
// Define XOR_FRAME_CHECKSUM_ROT_EN for a rotate-then-XOR (order-sensitive) checksum.
module xor_frame_checksum #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    input  logic                           invert,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_sum,
    output logic [$clog2(MAX_LEN+1)-1:0]   out_len,
    output logic                           out_err
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_mix;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   out_sum_q;
    logic [LEN_W-1:0]   out_len_q;
    logic               out_err_q;
    logic               accept, first, close;

    assign out_valid = (state_q == StDone);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // Any accept outside ACC opens a fresh frame.
    assign first     = (state_q != StAcc);

`ifdef XOR_FRAME_CHECKSUM_ROT_EN
    // Shift form keeps WIDTH=1 legal: rotl of one bit is itself.
    assign acc_mix = ((acc_q << 1) | (acc_q >> (WIDTH - 1))) ^ in_data;
`else
    assign acc_mix = acc_q ^ in_data;
`endif

    always_comb begin
        acc_d  = first ? in_data : acc_mix;
        len_d  = first ? LEN_W'(1) : len_q + LEN_W'(1);
        mode_d = first ? invert : mode_q;
        close  = in_last || (len_d == LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            out_sum_q <= '0;
            out_len_q <= '0;
            out_err_q <= 1'b0;
        end else if (accept) begin
            acc_q  <= acc_d;
            len_q  <= len_d;
            mode_q <= mode_d;
            if (close) begin
                state_q   <= StDone;
                out_sum_q <= acc_d ^ {WIDTH{mode_d}};
                out_len_q <= len_d;
                out_err_q <= !in_last;
            end else begin
                state_q <= StAcc;
            end
        end else if (state_q == StDone && out_ready) begin
            state_q <= StIdle;
        end
    end

    assign out_sum = out_sum_q;
    assign out_len = out_len_q;
    assign out_err = out_err_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum (WIDTH=8, MAX_LEN=4); expectations follow the build macro.
module tb_xor_frame_checksum;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_last, invert;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready, out_err;
    logic [WIDTH-1:0] out_sum;
    logic [LEN_W-1:0] out_len;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .invert    (invert),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_len   (out_len),
        .out_err   (out_err)
    );

`ifdef XOR_FRAME_CHECKSUM_ROT_EN
    localparam logic [7:0] ExpBasic = 8'hE1;
    localparam logic [7:0] ExpTrunc = 8'h02;
    localparam logic [7:0] ExpOrder = 8'h02;
`else
    localparam logic [7:0] ExpBasic = 8'hC3;
    localparam logic [7:0] ExpTrunc = 8'h04;
    localparam logic [7:0] ExpOrder = 8'h80;
`endif

    // Present one word, let one edge pass, then withdraw it (sampling point is edge+1).
    task automatic push(input logic [7:0] d, input logic last, input logic inv);
        in_valid = 1'b1; in_data = d; in_last = last; invert = inv;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'hEE; in_last = 1'b0; invert = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
        push(8'hFF, 1'b0, 1'b1);
        push(8'h77, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h want 00", out_sum); end
        checks++; if (out_len !== 3'd0) begin errors++; $display("FAIL midrst_len: got %0d want 0", out_len); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", out_err); end
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        push(8'h12, 1'b1, 1'b0);
        checks++; if (out_sum !== 8'h12) begin errors++; $display("FAIL postrst_sum: got %h want 12", out_sum); end
        checks++; if (out_len !== 3'd1) begin errors++; $display("FAIL postrst_len: got %0d want 1", out_len); end
        tick();
    endtask

    task automatic test_basic();
        push(8'h0F, 1'b0, 1'b0);
        push(8'hF0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", out_valid); end
        push(8'h3C, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== ExpBasic) begin errors++; $display("FAIL basic_sum: got %h want %h", out_sum, ExpBasic); end
        checks++; if (out_len !== 3'd3) begin errors++; $display("FAIL basic_len: got %0d want 3", out_len); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", out_err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_invert();
        push(8'hA5, 1'b1, 1'b1);
        checks++; if (out_sum !== 8'h5A) begin errors++; $display("FAIL inv_sum: got %h want 5a", out_sum); end
        checks++; if (out_len !== 3'd1) begin errors++; $display("FAIL inv_len: got %0d want 1", out_len); end
        tick();
        push(8'h0F, 1'b0, 1'b1);
        push(8'hF0, 1'b0, 1'b0);
        push(8'h3C, 1'b1, 1'b0);
        checks++; if (out_sum !== ~ExpBasic) begin errors++; $display("FAIL inv_hold: got %h want %h", out_sum, ~ExpBasic); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(8'h66, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1; invert = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_sum !== 8'h66 || out_len !== 3'd1)
                begin errors++; $display("FAIL bp_hold%0d: got v=%b sum=%h len=%0d want v=1 sum=66 len=1",
                      i, out_valid, out_sum, out_len); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1; in_data = 8'h11; invert = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'h11)
            begin errors++; $display("FAIL bp_next: got v=%b sum=%h want v=1 sum=11", out_valid, out_sum); end
        tick();
    endtask

    task automatic test_truncate();
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        push(8'h04, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_sum !== ExpTrunc)
            begin errors++; $display("FAIL trunc_sum: got v=%b sum=%h want v=1 sum=%h", out_valid, out_sum, ExpTrunc); end
        checks++; if (out_len !== 3'd4) begin errors++; $display("FAIL trunc_len: got %0d want 4", out_len); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL trunc_err: got %b want 1", out_err); end
        push(8'h05, 1'b1, 1'b0);
        checks++; if (out_sum !== 8'h05 || out_len !== 3'd1 || out_err !== 1'b0)
            begin errors++; $display("FAIL trunc_rest: got sum=%h len=%0d err=%b want 05/1/0", out_sum, out_len, out_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            push(words[i], 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_sum !== words[i])
                begin errors++; $display("FAIL b2b%0d: got v=%b sum=%h want v=1 sum=%h", i, out_valid, out_sum, words[i]); end
        end
        tick();
    endtask

    task automatic test_order();
        push(8'h81, 1'b0, 1'b0);
        push(8'h01, 1'b1, 1'b0);
        checks++; if (out_sum !== ExpOrder || out_len !== 3'd2)
            begin errors++; $display("FAIL order_sum: got sum=%h len=%0d want %h/2", out_sum, out_len, ExpOrder); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; invert = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_invert();
        test_backpressure();
        test_truncate();
        test_back_to_back();
        test_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
